// File: rtl/data_break_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_break_arbiter_if
// Bundles the CPU state, break request lines and memory-side control outputs
// that pass between the data-break arbiter and the rest of the machine.
//
// Signals:
//   cpu_state  5     current CPU major state code
//   brk_req    NREQ  level request per break requester
//   brk_wr     NREQ  per-requester write flag, sampled when the break is accepted
//   cpu_hold   1     CPU sequencer stays in its current state while high
//   mem_break  1     memory mux select (1 = break requester, 0 = CPU)
//   brk_grant  NREQ  one-hot grant, valid while the break cycle runs
//   mem_we     1     one-clock write strobe for break writes
//   brk_done   NREQ  one-clock completion pulse to the granted requester
//   brk_busy   1     high while the break cycle runs
//
// Modports:
//   slave  - the arbiter itself
//   master - the CPU / requester side that drives the inputs
// ---------------------------------------------------------------------------
interface data_break_arbiter_if #(
  parameter int NREQ = 4
);
  logic [4:0]      cpu_state;
  logic [NREQ-1:0] brk_req;
  logic [NREQ-1:0] brk_wr;
  logic            cpu_hold;
  logic            mem_break;
  logic [NREQ-1:0] brk_grant;
  logic            mem_we;
  logic [NREQ-1:0] brk_done;
  logic            brk_busy;

  modport slave (
    input  cpu_state, brk_req, brk_wr,
    output cpu_hold, mem_break, brk_grant, mem_we, brk_done, brk_busy
  );

  modport master (
    output cpu_state, brk_req, brk_wr,
    input  cpu_hold, mem_break, brk_grant, mem_we, brk_done, brk_busy
  );
endinterface

// File: rtl/data_break_arbiter.sv
// ---------------------------------------------------------------------------
// data_break_arbiter
// Shares the memory bus between the CPU major-state sequencer and up to NREQ
// data-break requesters. A break is only accepted while the CPU sits at a
// major-cycle boundary (F0, D0, E0, H0); the CPU is then held in that state
// while the break runs its memory timing sequence B0, B1, B2, B3. Breaks can
// chain back-to-back from B3 straight into B0, limited by MAX_BURST so the
// CPU always gets to advance eventually.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of data_break_arbiter_if (see that file for signals)
//
// Parameters:
//   NREQ         number of break requesters (1..8)
//   ROUND_ROBIN  0 = fixed priority (index 0 highest), 1 = rotating priority
//   MAX_BURST    consecutive breaks before the CPU must advance; 0 = unlimited
//   *_CODE       CPU major-state codes that count as cycle boundaries
// ---------------------------------------------------------------------------
module data_break_arbiter #(
  parameter int         NREQ        = 4,
  parameter int         ROUND_ROBIN = 0,
  parameter int         MAX_BURST   = 3,
  parameter logic [4:0] F0_CODE     = 5'd0,
  parameter logic [4:0] D0_CODE     = 5'd4,
  parameter logic [4:0] E0_CODE     = 5'd8,
  parameter logic [4:0] H0_CODE     = 5'd12
) (
  input logic                 clk,
  input logic                 reset,
  data_break_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_B3   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [NREQ-1:0] r_grant;
  logic [IW-1:0]   r_winIdx;
  logic            r_wr;
  logic [CW-1:0]   r_burstCnt;
  logic [IW-1:0]   r_rrPtr;
  logic [4:0]      r_prevCpu;

  logic            w_boundary;
  logic            w_exhausted;
  logic            w_start;
  logic            w_latch;
  logic [IW-1:0]   w_ptrAfter;
  logic [IW-1:0]   w_searchBase;
  logic [IW-1:0]   w_winIdx;
  logic [NREQ-1:0] w_winOneHot;
  logic [CW-1:0]   w_cntInc;
  logic            w_limitAfter;
  logic            w_rearm;

  // Scan the request vector starting at 'base' and wrapping around; the first
  // set bit wins. With base fixed at zero this is plain fixed priority.
  function automatic logic [IW-1:0] pickIndex(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   base);
    int   idx;
    logic found;
    pickIndex = '0;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(base) + i) % NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pickIndex = IW'(idx);
      end
    end
  endfunction

  assign w_boundary  = (bus.cpu_state == F0_CODE) || (bus.cpu_state == D0_CODE) ||
                       (bus.cpu_state == E0_CODE) || (bus.cpu_state == H0_CODE);
  assign w_exhausted = (MAX_BURST != 0) && (r_burstCnt == CW'(MAX_BURST));
  assign w_start     = (|bus.brk_req) && w_boundary && !w_exhausted && !reset;

  // Rotating pointer value after the current winner finishes. During B3 the
  // re-arbitration must already search from this value, because the pointer
  // register only moves on the same edge that re-enters B0.
  assign w_ptrAfter   = (r_winIdx == IW'(NREQ - 1)) ? '0 : r_winIdx + 1'b1;
  assign w_searchBase = (ROUND_ROBIN == 0) ? '0 :
                        (r_state == S_B3) ? w_ptrAfter : r_rrPtr;
  assign w_winIdx     = pickIndex(bus.brk_req, w_searchBase);

  // Burst count as it will be after this B3, saturating at the limit; the
  // chaining decision is made against this post-increment value.
  assign w_cntInc     = (MAX_BURST == 0) ? r_burstCnt :
                        (r_burstCnt == CW'(MAX_BURST)) ? r_burstCnt : r_burstCnt + 1'b1;
  assign w_limitAfter = (MAX_BURST != 0) && (w_cntInc == CW'(MAX_BURST));
  assign w_rearm      = (|bus.brk_req) && !w_limitAfter;

  // Build the one-hot form of the winning index so the grant register can
  // drive brk_grant and brk_done directly.
  always_comb begin
    w_winOneHot           = '0;
    w_winOneHot[w_winIdx] = 1'b1;
  end

  // State register. Reset mid-break drops straight back to idle, so the
  // aborted cycle never reaches its write strobe or completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. The CPU hold is asserted on the accept clock
  // itself so the sequencer cannot leave the boundary state on the edge where
  // the break is taken. All outputs are forced low while reset is asserted.
  always_comb begin
    w_nextState   = r_state;
    w_latch       = 1'b0;
    bus.cpu_hold  = 1'b0;
    bus.mem_break = 1'b0;
    bus.brk_busy  = 1'b0;
    bus.brk_grant = '0;
    bus.mem_we    = 1'b0;
    bus.brk_done  = '0;
    case (r_state)
      S_IDLE: begin
        bus.cpu_hold = w_start;
        if (w_start) begin
          w_nextState = S_B0;
          w_latch     = 1'b1;
        end
      end
      S_B0, S_B1, S_B2, S_B3: begin
        bus.cpu_hold  = 1'b1;
        bus.mem_break = 1'b1;
        bus.brk_busy  = 1'b1;
        bus.brk_grant = r_grant;
        case (r_state)
          S_B0: w_nextState = S_B1;
          S_B1: w_nextState = S_B2;
          S_B2: begin
            bus.mem_we  = r_wr;
            w_nextState = S_B3;
          end
          default: begin
            bus.brk_done = r_grant;
            if (w_rearm) begin
              w_nextState = S_B0;
              w_latch     = 1'b1;
            end else begin
              w_nextState = S_IDLE;
            end
          end
        endcase
      end
      default: w_nextState = S_IDLE;
    endcase
    if (reset) begin
      bus.cpu_hold  = 1'b0;
      bus.mem_break = 1'b0;
      bus.brk_busy  = 1'b0;
      bus.brk_grant = '0;
      bus.mem_we    = 1'b0;
      bus.brk_done  = '0;
    end
  end

  // Datapath registers: the winner and its write flag are captured once at
  // acceptance, so later request/write changes cannot disturb a running
  // cycle. The burst count only clears while idle and only when the CPU has
  // actually moved to a different state since the previous clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant    <= '0;
      r_winIdx   <= '0;
      r_wr       <= 1'b0;
      r_burstCnt <= '0;
      r_rrPtr    <= '0;
      r_prevCpu  <= bus.cpu_state;
    end else begin
      r_prevCpu <= bus.cpu_state;
      if (w_latch) begin
        r_grant  <= w_winOneHot;
        r_winIdx <= w_winIdx;
        r_wr     <= bus.brk_wr[w_winIdx];
      end
      if (r_state == S_B3) begin
        r_burstCnt <= w_cntInc;
        r_rrPtr    <= w_ptrAfter;
      end else if ((r_state == S_IDLE) && (bus.cpu_state != r_prevCpu)) begin
        r_burstCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_break_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_break_arbiter
// Directed bench for data_break_arbiter. Two instances share the same input
// stimulus: one with fixed priority, one with round-robin priority, both with
// a burst limit of three. Inputs change 1 time unit after the rising edge and
// outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_data_break_arbiter;

  localparam logic [4:0] F0 = 5'd0;
  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;
  localparam logic [4:0] D0 = 5'd4;
  localparam logic [4:0] D1 = 5'd5;
  localparam logic [4:0] E0 = 5'd8;
  localparam logic [4:0] H0 = 5'd12;

  logic clk;
  logic reset;

  int checkCount;
  int errorCount;

  logic       curRst;
  logic [4:0] curCpu;
  logic [3:0] curReq;
  logic [3:0] curWr;

  data_break_arbiter_if #(.NREQ(4)) ifFix ();
  data_break_arbiter_if #(.NREQ(4)) ifRr ();

  data_break_arbiter #(.NREQ(4), .ROUND_ROBIN(0), .MAX_BURST(3)) dutFix (
    .clk   (clk),
    .reset (reset),
    .bus   (ifFix.slave)
  );

  data_break_arbiter #(.NREQ(4), .ROUND_ROBIN(1), .MAX_BURST(3)) dutRr (
    .clk   (clk),
    .reset (reset),
    .bus   (ifRr.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Advance to just after the next rising edge and drive one input vector
  // into both instances.
  task automatic applyStimulus(input logic rst, input logic [4:0] cpu,
                               input logic [3:0] req, input logic [3:0] wr);
    @(posedge clk);
    #1;
    reset           = rst;
    ifFix.cpu_state = cpu;
    ifFix.brk_req   = req;
    ifFix.brk_wr    = wr;
    ifRr.cpu_state  = cpu;
    ifRr.brk_req    = req;
    ifRr.brk_wr     = wr;
    curRst          = rst;
    curCpu          = cpu;
    curReq          = req;
    curWr           = wr;
  endtask

  // Compare every output of the chosen instance at the falling edge.
  // Packed as {hold, mem_break, busy, mem_we, grant[3:0], done[3:0]}.
  task automatic checkOutput(input string tag, input bit useRr,
                             input logic hold, input logic mb, input logic busy,
                             input logic we, input logic [3:0] grant,
                             input logic [3:0] done);
    logic [11:0] obs;
    logic [11:0] expv;
    @(negedge clk);
    if (useRr)
      obs = {ifRr.cpu_hold, ifRr.mem_break, ifRr.brk_busy, ifRr.mem_we,
             ifRr.brk_grant, ifRr.brk_done};
    else
      obs = {ifFix.cpu_hold, ifFix.mem_break, ifFix.brk_busy, ifFix.mem_we,
             ifFix.brk_grant, ifFix.brk_done};
    expv = {hold, mb, busy, we, grant, done};
    checkCount++;
    assert (obs === expv) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %b expected %b (hold,mb,busy,we,grant,done)",
             tag, obs, expv);
    end
  endtask

  // One complete break B0..B3 with the given grant; the request vector is
  // replaced by reqAfter during B0, after the winner is already latched.
  task automatic runBreak(input string tag, input bit useRr,
                          input logic [3:0] grant, input logic we,
                          input logic [3:0] reqAfter);
    applyStimulus(curRst, curCpu, reqAfter, curWr);
    checkOutput({tag, "_B0"}, useRr, 1'b1, 1'b1, 1'b1, 1'b0, grant, 4'b0000);
    applyStimulus(curRst, curCpu, curReq, curWr);
    checkOutput({tag, "_B1"}, useRr, 1'b1, 1'b1, 1'b1, 1'b0, grant, 4'b0000);
    applyStimulus(curRst, curCpu, curReq, curWr);
    checkOutput({tag, "_B2"}, useRr, 1'b1, 1'b1, 1'b1, we, grant, 4'b0000);
    applyStimulus(curRst, curCpu, curReq, curWr);
    checkOutput({tag, "_B3"}, useRr, 1'b1, 1'b1, 1'b1, 1'b0, grant, grant);
  endtask

  // Directed test sequence.
  initial begin
    clk             = 1'b0;
    reset           = 1'b1;
    checkCount      = 0;
    errorCount      = 0;
    ifFix.cpu_state = F1;
    ifFix.brk_req   = '0;
    ifFix.brk_wr    = '0;
    ifRr.cpu_state  = F1;
    ifRr.brk_req    = '0;
    ifRr.brk_wr     = '0;
    curRst          = 1'b1;
    curCpu          = F1;
    curReq          = '0;
    curWr           = '0;

    $display("[TB] reset state");
    applyStimulus(1'b1, F1, 4'b0000, 4'b0000);
    checkOutput("resetFix", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b1, F1, 4'b0000, 4'b0000);
    checkOutput("resetRr", 1, 0, 0, 0, 0, 4'b0000, 4'b0000);

    $display("[TB] single write request at F0");
    applyStimulus(1'b0, F0, 4'b0001, 4'b0001);
    checkOutput("singleAccept", 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
    runBreak("single", 0, 4'b0001, 1'b1, 4'b0000);
    applyStimulus(1'b0, F0, 4'b0000, 4'b0000);
    checkOutput("singleIdle", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, F1, 4'b0000, 4'b0000);
    checkOutput("singleCpuMoves", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);

    $display("[TB] request raised in a non-boundary state");
    applyStimulus(1'b0, F2, 4'b0001, 4'b0000);
    checkOutput("nbF2", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, F3, 4'b0001, 4'b0000);
    checkOutput("nbF3", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, F0, 4'b0001, 4'b0000);
    checkOutput("nbF0Accept", 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
    runBreak("nbRead", 0, 4'b0001, 1'b0, 4'b0000);

    $display("[TB] fixed priority back-to-back");
    applyStimulus(1'b0, E0, 4'b1010, 4'b1010);
    checkOutput("fpAccept", 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
    runBreak("fpFirst", 0, 4'b0010, 1'b1, 4'b1000);
    runBreak("fpSecond", 0, 4'b1000, 1'b1, 4'b0000);
    applyStimulus(1'b0, E0, 4'b0000, 4'b0000);
    checkOutput("fpIdle", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);

    $display("[TB] burst limit");
    applyStimulus(1'b0, D0, 4'b0001, 4'b0000);
    checkOutput("burstAccept", 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++)
      runBreak("burst", 0, 4'b0001, 1'b0, 4'b0001);
    applyStimulus(1'b0, D0, 4'b0001, 4'b0000);
    checkOutput("burstExhausted", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, D0, 4'b0001, 4'b0000);
    checkOutput("burstStillHeld", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, D1, 4'b0001, 4'b0000);
    checkOutput("burstCpuMoves", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, E0, 4'b0001, 4'b0000);
    checkOutput("burstResume", 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
    runBreak("burstResumed", 0, 4'b0001, 1'b0, 4'b0000);

    $display("[TB] reset during B1");
    applyStimulus(1'b0, H0, 4'b0001, 4'b0001);
    checkOutput("rstAccept", 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, H0, 4'b0001, 4'b0001);
    checkOutput("rstB0", 0, 1, 1, 1, 0, 4'b0001, 4'b0000);
    applyStimulus(1'b1, H0, 4'b0001, 4'b0001);
    checkOutput("rstInB1", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b1, H0, 4'b0001, 4'b0001);
    checkOutput("rstNoWeDone", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, H0, 4'b0001, 4'b0001);
    checkOutput("rstReaccept", 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
    runBreak("rstAfter", 0, 4'b0001, 1'b1, 4'b0000);
    applyStimulus(1'b0, H0, 4'b0000, 4'b0000);
    checkOutput("rstIdle", 0, 0, 0, 0, 0, 4'b0000, 4'b0000);

    $display("[TB] round robin");
    applyStimulus(1'b1, F1, 4'b0000, 4'b0000);
    applyStimulus(1'b1, F1, 4'b0000, 4'b0000);
    checkOutput("rrReset", 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, F0, 4'b1111, 4'b0000);
    checkOutput("rrAccept", 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
    runBreak("rrGrant0", 1, 4'b0001, 1'b0, 4'b1111);
    runBreak("rrGrant1", 1, 4'b0010, 1'b0, 4'b1111);
    runBreak("rrGrant2", 1, 4'b0100, 1'b0, 4'b1111);
    applyStimulus(1'b0, F0, 4'b1111, 4'b0000);
    checkOutput("rrExhausted", 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, F1, 4'b1111, 4'b0000);
    checkOutput("rrCpuMoves", 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, D0, 4'b1111, 4'b0000);
    checkOutput("rrReaccept", 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
    runBreak("rrGrant3", 1, 4'b1000, 1'b0, 4'b1111);
    runBreak("rrGrant0again", 1, 4'b0001, 1'b0, 4'b0000);
    applyStimulus(1'b0, D0, 4'b0000, 4'b0000);
    checkOutput("rrIdle", 1, 0, 0, 0, 0, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
